// File: rtl/ola_hanning.sv
// Overlap-add synthesis stage: hanning-windows IFFT frames and
// overlap-adds the first half with the stored second half of the last frame.
module ola_hanning #(
  parameter int FRAME_LEN = 1024,
  parameter int HOP       = 512,
  parameter int DW        = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic          in_sof,
  input  logic [DW-1:0] in_data,
  output logic [9:0]    win_addr,
  input  logic [15:0]   win_q,
  output logic          out_valid,
  output logic          out_sof,
  output logic [DW-1:0] out_data,
  output logic          frame_err
);

  localparam int AW = $clog2(FRAME_LEN);
  localparam int HW = $clog2(HOP);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_cnt, w_cnt_nxt;
  logic          r_first, w_first_nxt;
  logic          r_err, w_err_nxt;
  logic          w_acc;
  logic [AW-1:0] w_k;

  logic          r_v1;
  logic [AW-1:0] r_k1;
  logic [DW-1:0] r_d1;
  logic          r_ff1;

  logic [DW-1:0] r_mem [HOP];
  logic [DW-1:0] r_ovl_q;

  logic          r_ov;
  logic          r_osof;
  logic [DW-1:0] r_odata;

  logic signed [DW+16:0] w_prod;
  logic signed [DW-1:0]  w_w;
  logic signed [DW:0]    w_sum;
  logic [DW-1:0]         w_sat;

  assign w_k      = (in_valid && in_sof) ? '0 : r_cnt;
  assign win_addr = 10'(w_k);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_first <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_first <= w_first_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_first_nxt = r_first;
    w_err_nxt   = r_err;
    w_acc       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          if (in_sof) begin
            w_acc       = 1'b1;
            w_state_nxt = S_RUN;
            w_cnt_nxt   = AW'(1);
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (in_valid) begin
          w_acc = 1'b1;
          if (in_sof && r_cnt != '0) w_err_nxt = 1'b1;
          w_cnt_nxt = w_k + AW'(1);
          if (w_k == AW'(FRAME_LEN - 1)) begin
            w_state_nxt = S_IDLE;
            w_first_nxt = 1'b0;
            w_cnt_nxt   = '0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1  <= 1'b0;
      r_k1  <= '0;
      r_d1  <= '0;
      r_ff1 <= 1'b1;
    end else begin
      r_v1 <= w_acc;
      if (w_acc) begin
        r_k1  <= w_k;
        r_d1  <= in_data;
        r_ff1 <= r_first;
      end
    end
  end

  // Overlap RAM is deliberately not reset; r_ff1 masks stale contents.
  always_ff @(posedge clk) begin
    if (w_acc) r_ovl_q <= r_mem[w_k[HW-1:0]];
    if (r_v1 && r_k1[AW-1]) r_mem[r_k1[HW-1:0]] <= w_w;
  end

  assign w_prod = $signed(r_d1) * $signed({1'b0, win_q});
  assign w_w    = DW'(w_prod >>> 16);
  assign w_sum  = {w_w[DW-1], w_w}
                + (r_ff1 ? '0 : {r_ovl_q[DW-1], r_ovl_q});

  always_comb begin
    w_sat = w_sum[DW-1:0];
    if (w_sum[DW] != w_sum[DW-1])
      w_sat = w_sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ov    <= 1'b0;
      r_osof  <= 1'b0;
      r_odata <= '0;
    end else begin
      r_ov   <= r_v1 && !r_k1[AW-1];
      r_osof <= r_v1 && (r_k1 == '0);
      if (r_v1 && !r_k1[AW-1]) r_odata <= w_sat;
    end
  end

  assign out_valid = r_ov;
  assign out_sof   = r_osof;
  assign out_data  = r_odata;
  assign frame_err = r_err;

endmodule

// File: tb/tb_ola_hanning.sv
// Bench for ola_hanning: table-driven constant-window frames plus
// randomized frames checked against a frame-level overlap-add model.
module tb_ola_hanning;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_sof;
  logic [15:0] in_data;
  logic [9:0]  win_addr;
  logic [15:0] win_q;
  logic        out_valid, out_sof, frame_err;
  logic [15:0] out_data;

  always #5 clk = ~clk;

  ola_hanning dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .win_addr(win_addr), .win_q(win_q),
    .out_valid(out_valid), .out_sof(out_sof), .out_data(out_data),
    .frame_err(frame_err)
  );

  logic [15:0] rom [1024];
  always @(posedge clk) win_q <= rom[win_addr];

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  typedef struct {
    logic [15:0] d;
    logic        sof;
    int          cyc;
  } exp_t;
  exp_t q[$];

  int   m_run, m_k, m_first;
  int   m_err;
  int   m_ovl [512];
  logic tmode = 1'b0;
  logic [15:0] tab_e1, tab_e2;

  function automatic int win_mul(logic [15:0] d, logic [15:0] w);
    longint p;
    p = longint'($signed(d)) * longint'(w);
    return int'(p >>> 16);
  endfunction

  function automatic logic [15:0] sat16(int v);
    if (v > 32767) return 16'h7fff;
    if (v < -32768) return 16'h8000;
    return 16'(v);
  endfunction

  task automatic model_reset();
    m_run = 0; m_k = 0; m_first = 1; m_err = 0;
  endtask

  task automatic model(logic v, logic s, logic [15:0] d);
    int w, o;
    exp_t e;
    if (!v) return;
    if (s) begin
      if (m_run != 0 && m_k != 0) m_err = 1;
      m_k = 0; m_run = 1;
    end else if (m_run == 0) begin
      m_err = 1;
      return;
    end
    w = win_mul(d, rom[m_k]);
    if (m_k < 512) begin
      o = w + ((m_first != 0) ? 0 : m_ovl[m_k]);
      e.d   = tmode ? ((m_first != 0) ? tab_e1 : tab_e2) : sat16(o);
      e.sof = (m_k == 0);
      e.cyc = cyc + 2;
      q.push_back(e);
    end else begin
      m_ovl[m_k - 512] = w;
    end
    m_k++;
    if (m_k == 1024) begin m_run = 0; m_first = 0; m_k = 0; end
  endtask

  task automatic send(logic v, logic s, logic [15:0] d);
    @(posedge clk); #1;
    in_valid = v; in_sof = s; in_data = d;
    model(v, s, d);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0; in_sof = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
    q.delete();
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic rom_fill(logic [15:0] v);
    for (int i = 0; i < 1024; i++) rom[i] = v;
  endtask

  task automatic rom_rand();
    for (int i = 0; i < 1024; i++) rom[i] = 16'($urandom);
  endtask

  function automatic logic [15:0] rnd_data();
    case ($urandom_range(7))
      0: return 16'h7fff;
      1: return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      n_chk++;
      $display("FAIL missing_out: got none required %h at cycle %0d", q[0].d, q[0].cyc);
      void'(q.pop_front());
    end
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL spurious_out: got %h required no output (cycle %0d)", out_data, cyc);
      end else begin
        e = q.pop_front();
        chk("out_data", int'(out_data), int'(e.d));
        chk("out_sof", int'(out_sof), int'(e.sof));
        chk("out_cycle", cyc, e.cyc);
      end
    end
  end

  typedef struct {
    logic [15:0] rom;
    logic [15:0] din;
    logic [15:0] e1;
    logic [15:0] e2;
  } vec_t;
  vec_t tv [7];

  initial begin
    in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
    rom_fill(16'h0000);
    model_reset();

    tv[0] = '{16'h8000, 16'h4000, 16'h2000, 16'h4000};
    tv[1] = '{16'hffff, 16'h7fff, 16'h7ffe, 16'h7fff};
    tv[2] = '{16'hffff, 16'h8000, 16'h8000, 16'h8000};
    tv[3] = '{16'h8000, 16'hc000, 16'he000, 16'hc000};
    tv[4] = '{16'h0000, 16'h1234, 16'h0000, 16'h0000};
    tv[5] = '{16'h4000, 16'h7fff, 16'h1fff, 16'h3ffe};
    tv[6] = '{16'h4000, 16'h8001, 16'he000, 16'hc000};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sof", int'(out_sof), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    chk("rst_win_addr", int'(win_addr), 0);
    rst_n = 1'b1;

    // constant window, two back-to-back frames per vector
    for (int i = 0; i < 7; i++) begin
      do_reset();
      rom_fill(tv[i].rom);
      tmode = 1'b1; tab_e1 = tv[i].e1; tab_e2 = tv[i].e2;
      for (int f = 0; f < 2; f++)
        for (int k = 0; k < 1024; k++)
          send(1'b1, k == 0, tv[i].din);
      idle(6);
      tmode = 1'b0;
      chk("tab_drain", q.size(), 0);
      chk("tab_frame_err", int'(frame_err), 0);
    end

    // sof at k=300 restarts the frame
    do_reset();
    rom_rand();
    for (int k = 0; k < 300; k++) send(1'b1, k == 0, rnd_data());
    send(1'b1, 1'b1, rnd_data());
    idle(1);
    chk("ferr_set", int'(frame_err), 1);
    for (int k = 1; k < 1024; k++) send(1'b1, 1'b0, rnd_data());
    for (int k = 0; k < 1024; k++) send(1'b1, k == 0, rnd_data());
    idle(6);
    chk("ferr_sticky", int'(frame_err), m_err);
    chk("ferr_drain", q.size(), 0);

    // data without sof while idle is dropped
    do_reset();
    rom_fill(16'h8000);
    send(1'b1, 1'b0, 16'h4000);
    chk("idle_win_addr", int'(win_addr), 0);
    send(1'b1, 1'b0, 16'h1111);
    idle(6);
    chk("idle_drop_err", int'(frame_err), 1);
    chk("idle_drop_q", q.size(), 0);

    // reset in the middle of frame 2
    do_reset();
    rom_fill(16'h8000);
    for (int k = 0; k < 1024; k++) send(1'b1, k == 0, 16'h4000);
    for (int k = 0; k <= 700; k++) send(1'b1, k == 0, 16'h4000);
    do_reset();
    idle(10);
    chk("rst_mid_quiet", int'(out_valid), 0);
    chk("rst_mid_err", int'(frame_err), 0);
    tmode = 1'b1; tab_e1 = 16'h2000; tab_e2 = 16'h4000;
    for (int k = 0; k < 1024; k++) send(1'b1, k == 0, 16'h4000);
    idle(6);
    tmode = 1'b0;
    chk("rst_mid_drain", q.size(), 0);

    // randomized window and data with gaps
    do_reset();
    rom_rand();
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 1024; k++) begin
        while ($urandom_range(3) == 0) send(1'b0, 1'b0, 16'($urandom));
        send(1'b1, k == 0, rnd_data());
      end
    end
    idle(6);
    chk("rand_drain", q.size(), 0);
    chk("rand_frame_err", int'(frame_err), m_err);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
